counter_sequencer: RTL and testbench
====================================

# counter_sequencer

Control block for the two-digit push-button counter datapath. Conditions the two active-low push buttons, runs a RUN/PAUSE/IDLE state machine, generates the step tick from the 50 MHz clock, and holds a two-digit BCD count (00–99) that counts up or down. It drives the FND decoders (units and tens) and the LED bank, and replaces ad-hoc counting logic at the board top level.

## Interface
- CLK_HZ, 50_000_000, input clock frequency in Hz
- TICK_HZ, 2, count steps per second while running; CLK_HZ/TICK_HZ ≥ 2
- DB_CYCLES, 500_000, stable-level cycles needed to accept a button change (used only with debounce compiled in)
- i_Clk  input  1  system clock, 50 MHz
- i_Rst  input  1  synchronous, active-high reset
- i_Push  input  2  raw buttons, active-low, asynchronous; [0] = start/pause, [1] = direction
- o_Cnt1  output  4  BCD units digit, to FND decoder 1
- o_Cnt2  output  4  BCD tens digit, to FND decoder 2
- o_LED  output  4  status: [0] running, [1] paused, [2] direction (1 = down), [3] step pulse
- o_Tick  output  1  one-cycle pulse on every count step

## Operation
- Button conditioning (per bit): 2-FF synchroniser, then optional debounce, then falling-edge detect on the conditioned level. This gives press events pS (bit 0) and pD (bit 1). The conditioned level resets to 1 (released).
- Clear event: a press event on either button while the other conditioned level is 0 (held). It also fires when both events occur in the same cycle. A clear suppresses pS and pD in that cycle.
- States: IDLE, RUN, PAUSE.
  - IDLE: pS → RUN.
  - RUN: pS → PAUSE.
  - PAUSE: pS → RUN.
  - Clear in any state → IDLE, count 00, prescaler 0. Direction is kept.
- pD toggles direction in every state.
- Prescaler: counts 0..CLK_HZ/TICK_HZ−1 only in RUN and wraps to 0; the step fires on the wrap.
  - Prescaler clears to 0 on entry to RUN, so the first step comes exactly CLK_HZ/TICK_HZ cycles after the transition.
  - In PAUSE the prescaler holds its value; it is cleared anyway on the next RUN entry.
- Step, up direction: units +1. Units 9 → 0 with carry, tens +1. 99 → 00.
- Step, down direction: units −1. Units 0 → 9 with borrow, tens −1. 00 → 99.
- Digits never leave the 0–9 range; no binary-to-BCD division.
- Priority within one cycle: clear > pS > step. A step coinciding with pS in RUN is dropped; the state goes to PAUSE and the count is unchanged. pD in the same cycle as a step takes effect from the next step; the current step uses the old direction.

## Timing
- All outputs are registered.
- Reset values: o_Cnt1 = 0, o_Cnt2 = 0, o_Tick = 0, o_LED = 4'b0000. State is IDLE, direction is up, prescaler is 0.
- Button latency, from a raw edge to the state/direction change:
  - Without debounce: 3 cycles (2 sync + 1 edge register).
  - With debounce: 3 + DB_CYCLES cycles.
- Count latency: the digits update in the same cycle o_Tick is high. o_LED[3] equals o_Tick.
- Reset mid-run: i_Rst sampled high forces all reset values on the next edge, regardless of state. Pending presses are lost.

## Configuration
- COUNTER_SEQ_DEBOUNCE_EN
  - Defined: each button level updates only after the synchronised input has differed from it for DB_CYCLES consecutive cycles. Any bounce restarts the count.
  - Undefined: the conditioned level equals the synchroniser output. DB_CYCLES is ignored and no debounce counters are built.

## Structure
- Shared package counter_pkg holds:
  - the state enum (IDLE, RUN, PAUSE);
  - BCD_MAX = 4'd9;
  - the direction encoding (UP = 0, DN = 1);
  - the LED bit-index constants.
- Sub-module push_cond: synchroniser, optional debounce, falling-edge detect. It outputs the conditioned level and the press pulse, and is instantiated twice.
- FND decoding stays outside this block, in the existing FND module.

## Test plan
Run with CLK_HZ=8, TICK_HZ=1 (8-cycle step); debounce variant uses DB_CYCLES=4.
- Reset, then press i_Push[0] → RUN after 3 cycles. o_Tick at cycles +8 and +16; digits read 01, then 02. o_LED = 4'b0001 between ticks.
- Preload to 09 by steps, one more step → 10. Run to 99, one more step → 00, tick still pulses.
- Press i_Push[1] at count 00 in RUN → next step gives 99. Down from 10 → 09.
- Press i_Push[0] on the same cycle as a scheduled step → PAUSE, count unchanged. Later press → RUN, next step exactly 8 cycles after.
- Hold i_Push[1] low, then press i_Push[0] → clear: IDLE, 00, direction kept. Assert i_Rst mid-RUN → all reset values on the next edge.
- COUNTER_SEQ_DEBOUNCE_EN defined: a 3-cycle low glitch on i_Push[0] → no state change. A 6-cycle low press → RUN at raw edge + 7.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state, direction and LED encodings for counter_sequencer
package counter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   typedef enum logic {
      UP = 1'b0,
      DN = 1'b1
   } dir_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   localparam int LED_RUN   = 0;
   localparam int LED_PAUSE = 1;
   localparam int LED_DIR   = 2;
   localparam int LED_STEP  = 3;

   // One BCD step on {tens, units}; both digits wrap inside 0..9 so 99+1=00 and 00-1=99.
   function automatic logic [7:0] bcd_step(input logic [7:0] cnt, input dir_t dir);
      logic [3:0] units;
      logic [3:0] tens;
      units = cnt[3:0];
      tens  = cnt[7:4];
      if (dir == UP) begin
         if (units == BCD_MAX) begin
            units = 4'd0;
            tens  = (tens == BCD_MAX) ? 4'd0 : tens + 4'd1;
         end else begin
            units = units + 4'd1;
         end
      end else begin
         if (units == 4'd0) begin
            units = BCD_MAX;
            tens  = (tens == 4'd0) ? BCD_MAX : tens - 4'd1;
         end else begin
            units = units - 4'd1;
         end
      end
      return {tens, units};
   endfunction

endpackage

// File: rtl/counter_sequencer_if.sv
// rtl/counter_sequencer_if.sv - button inputs and display/status outputs of counter_sequencer
interface counter_sequencer_if;

   logic [1:0] i_Push;
   logic [3:0] o_Cnt1;
   logic [3:0] o_Cnt2;
   logic [3:0] o_LED;
   logic       o_Tick;

   modport master (
      output i_Push,
      input  o_Cnt1,
      input  o_Cnt2,
      input  o_LED,
      input  o_Tick
   );

   modport slave (
      input  i_Push,
      output o_Cnt1,
      output o_Cnt2,
      output o_LED,
      output o_Tick
   );

endinterface

// File: rtl/push_cond.sv
// rtl/push_cond.sv - one active-low button: 2-FF sync, optional debounce, falling-edge press pulse
// Debounce is built only when COUNTER_SEQ_DEBOUNCE_EN is defined.
module push_cond #(
   parameter int DB_CYCLES = 500_000
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic raw_n,
   output logic level,
   output logic press
);

   logic [1:0] sync_q;
   logic       level_q;

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], raw_n};
      end
   end

`ifdef COUNTER_SEQ_DEBOUNCE_EN
   localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic [DB_W-1:0] db_cnt_q;
   logic            db_level_q;

   // Any sample matching the held level restarts the count, so bounce never leaks through.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         db_cnt_q   <= '0;
         db_level_q <= 1'b1;
      end else if (sync_q[1] == db_level_q) begin
         db_cnt_q <= '0;
      end else if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
         db_level_q <= sync_q[1];
         db_cnt_q   <= '0;
      end else begin
         db_cnt_q <= db_cnt_q + DB_W'(1);
      end
   end

   assign level = db_level_q;
`else
   assign level = sync_q[1];
`endif

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         level_q <= 1'b1;
      end else begin
         level_q <= level;
      end
   end

   assign press = level_q & ~level;

endmodule

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - RUN/PAUSE/IDLE two-digit BCD up/down counter driven by two push buttons
// Optional button debounce: define COUNTER_SEQ_DEBOUNCE_EN.
module counter_sequencer
   import counter_pkg::*;
#(
   parameter int CLK_HZ    = 50_000_000,
   parameter int TICK_HZ   = 2,
   parameter int DB_CYCLES = 500_000
) (
   input  logic                i_Clk,
   input  logic                i_Rst,
   counter_sequencer_if.slave  bus
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [1:0]    level;
   logic [1:0]    press;
   logic          clear;
   logic          p_start;
   logic          p_dir;
   logic          step;
   logic          step_fire;
   logic          entering_run;
   state_t        state_q;
   state_t        state_d;
   dir_t          dir_q;
   dir_t          dir_d;
   logic [PW-1:0] presc_q;
   logic [7:0]    cnt_q;
   logic          tick_q;
   logic [3:0]    led_q;
   logic [3:0]    led_d;

   push_cond #(.DB_CYCLES(DB_CYCLES)) u_push_start (
      .i_Clk (i_Clk),
      .i_Rst (i_Rst),
      .raw_n (bus.i_Push[0]),
      .level (level[0]),
      .press (press[0])
   );

   push_cond #(.DB_CYCLES(DB_CYCLES)) u_push_dir (
      .i_Clk (i_Clk),
      .i_Rst (i_Rst),
      .raw_n (bus.i_Push[1]),
      .level (level[1]),
      .press (press[1])
   );

   // A press while the other button is held is a clear chord and swallows both press events.
   always_comb begin
      clear     = (press[0] & ~level[1]) | (press[1] & ~level[0]) | (press[0] & press[1]);
      p_start   = press[0] & ~clear;
      p_dir     = press[1] & ~clear;
      step      = (state_q == RUN) && (presc_q == PW'(DIV - 1));
      step_fire = step & ~clear & ~p_start;
      dir_d     = p_dir ? dir_t'(~dir_q) : dir_q;
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else if (p_start) begin
         case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = PAUSE;
            default: state_d = RUN;
         endcase
      end
   end

   assign entering_run = (state_d == RUN) && (state_q != RUN);

   always_comb begin
      led_d            = '0;
      led_d[LED_RUN]   = (state_d == RUN);
      led_d[LED_PAUSE] = (state_d == PAUSE);
      led_d[LED_DIR]   = (dir_d == DN);
      led_d[LED_STEP]  = step_fire;
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         presc_q <= '0;
         cnt_q   <= '0;
         dir_q   <= UP;
         tick_q  <= 1'b0;
         led_q   <= '0;
      end else begin
         // Zeroing on RUN entry makes the first step land a full period after start/resume.
         if (clear || entering_run) begin
            presc_q <= '0;
         end else if ((state_q == RUN) && (state_d == RUN)) begin
            presc_q <= step ? '0 : presc_q + PW'(1);
         end

         if (clear) begin
            cnt_q <= '0;
         end else if (step_fire) begin
            cnt_q <= bcd_step(cnt_q, dir_q);
         end

         dir_q  <= dir_d;
         tick_q <= step_fire;
         led_q  <= led_d;
      end
   end

   assign bus.o_Cnt1 = cnt_q[3:0];
   assign bus.o_Cnt2 = cnt_q[7:4];
   assign bus.o_LED  = led_q;
   assign bus.o_Tick = tick_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - scoreboard bench for counter_sequencer with a behavioural model
module tb_counter_sequencer;

   localparam int DIV = 8;
`ifdef COUNTER_SEQ_DEBOUNCE_EN
   localparam int DB = 4;
`else
   localparam int DB = 0;
`endif
   localparam int HOLD = DB + 2;
   localparam int GAP  = DB + 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   counter_sequencer_if bus ();

   counter_sequencer #(
      .CLK_HZ    (8),
      .TICK_HZ   (1),
      .DB_CYCLES (4)
   ) dut (
      .i_Clk (clk),
      .i_Rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int         cyc;
      int         count;
      logic [3:0] led;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;

   // Model: mode 0 idle, 1 run, 2 pause; count kept as a plain integer 0..99.
   int       m_mode;
   int       m_count;
   int       m_phase;
   bit       m_down;
   bit       m_tick;
   bit [1:0] raw_d1;
   bit [1:0] raw_d2;
   bit [1:0] lvl;
   bit [1:0] lvl_prev;
   bit [1:0] hist[$];

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] t;
      logic [3:0] u;
      t = 4'(v / 10);
      u = 4'(v % 10);
      return {t, u};
   endfunction

   function automatic logic [3:0] model_led();
      return {m_tick, m_down, (m_mode == 2), (m_mode == 1)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_status(input string name);
      check({name, "_cnt"}, {bus.o_Cnt2, bus.o_Cnt1}, to_bcd(m_count));
      check({name, "_led"}, bus.o_LED, model_led());
   endtask

   always @(posedge clk) begin
      bit [1:0] prs;
      bit [1:0] nl;
      bit       clr;
      bit       ps;
      bit       pd;
      bit       stp;
      bit       all_diff;
      exp_t     e;
      cyc++;
      if (rst) begin
         m_mode = 0; m_count = 0; m_phase = 0; m_down = 0; m_tick = 0;
         raw_d1 = 2'b11; raw_d2 = 2'b11; lvl = 2'b11; lvl_prev = 2'b11;
         hist.delete();
         sb.delete();
      end else begin
         prs = lvl_prev & ~lvl;
         clr = (prs[0] & ~lvl[1]) | (prs[1] & ~lvl[0]) | (prs[0] & prs[1]);
         ps  = prs[0] & ~clr;
         pd  = prs[1] & ~clr;
         // Conditioned level: the synchronised stream, or a debounced view of it.
         nl = lvl;
         if (DB == 0) begin
            nl = raw_d1;
         end else begin
            hist.push_back(raw_d2);
            if (hist.size() > DB) void'(hist.pop_front());
            if (hist.size() == DB) begin
               for (int b = 0; b < 2; b++) begin
                  all_diff = 1'b1;
                  foreach (hist[i]) if (hist[i][b] == lvl[b]) all_diff = 1'b0;
                  if (all_diff) nl[b] = ~lvl[b];
               end
            end
         end
         lvl_prev = lvl;
         lvl      = nl;
         raw_d2   = raw_d1;
         raw_d1   = bus.i_Push;

         m_tick = 1'b0;
         stp = (m_mode == 1) && (m_phase == DIV - 1);
         if (clr) begin
            m_mode = 0; m_count = 0; m_phase = 0;
         end else if (ps) begin
            if (m_mode == 1) m_mode = 2;
            else begin m_mode = 1; m_phase = 0; end
         end else if (m_mode == 1) begin
            if (stp) begin
               m_count = m_down ? (m_count + 99) % 100 : (m_count + 1) % 100;
               m_tick  = 1'b1;
            end
            m_phase = (m_phase + 1) % DIV;
         end
         if (pd) m_down = ~m_down;
         if (m_tick) begin
            e.cyc = cyc; e.count = m_count; e.led = model_led();
            sb.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
         check("tick_missing_cyc", cyc, sb[0].cyc);
         void'(sb.pop_front());
      end
      if (bus.o_Tick === 1'b1) begin
         if (sb.size() == 0) begin
            check("tick_unexpected", bus.o_Tick, 0);
         end else begin
            e = sb.pop_front();
            check("tick_cycle", cyc, e.cyc);
            check("tick_count", {bus.o_Cnt2, bus.o_Cnt1}, to_bcd(e.count));
            check("tick_led", bus.o_LED, e.led);
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_btn(input int b, input int len);
      bus.i_Push[b] = 1'b0;
      cycles(len);
      bus.i_Push[b] = 1'b1;
      cycles(GAP);
   endtask

   task automatic clear_seq();
      bus.i_Push[1] = 1'b0;
      cycles(HOLD + 3);
      bus.i_Push[0] = 1'b0;
      cycles(HOLD + 3);
      bus.i_Push = 2'b11;
      cycles(GAP);
   endtask

   task automatic wait_phase(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (m_mode == 1 && m_phase == target) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      bit ok;
      int saved;
      bus.i_Push = 2'b11;
      rst = 1'b1;
      cycles(3);
      check("rst_cnt1", bus.o_Cnt1, 0);
      check("rst_cnt2", bus.o_Cnt2, 0);
      check("rst_led", bus.o_LED, 0);
      check("rst_tick", bus.o_Tick, 0);
      rst = 1'b0;
      cycles(2);

      bus.i_Push[0] = 1'b0;
      cycles(2 + DB);
      check("pre_run_led", bus.o_LED, 4'b0000);
      cycles(1);
      check("run_entry_led", bus.o_LED, 4'b0001);
      bus.i_Push[0] = 1'b1;
      cycles(GAP);
      check_status("running");

      cycles(DIV * 100);
      check_status("after_wrap");

      push_btn(1, HOLD);
      cycles(DIV * 3);
      check_status("down_run");

      wait_phase(DIV - 3 - DB, ok);
      check("phase_align", ok, 1);
      saved = m_count;
      push_btn(0, HOLD);
      check("pause_cnt", {bus.o_Cnt2, bus.o_Cnt1}, to_bcd(saved));
      check("pause_led", bus.o_LED[1:0], 2'b10);
      cycles(5);
      push_btn(0, HOLD);
      cycles(DIV * 2);
      check_status("resumed");

      clear_seq();
      check("clear_cnt", {bus.o_Cnt2, bus.o_Cnt1}, 0);
      check("clear_state", bus.o_LED[1:0], 2'b00);
      check_status("clear");

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0:       push_btn(0, HOLD);
            1:       push_btn(1, HOLD);
            2:       clear_seq();
            default: cycles(1);
         endcase
         cycles($urandom_range(1, 3 * DIV));
         check_status($sformatf("rand%0d", i));
      end

      if (m_mode != 1) push_btn(0, HOLD);
      cycles(5);
      check("pre_reset_run", bus.o_LED[0], 1);
      rst = 1'b1;
      cycles(1);
      check("midrst_cnt", {bus.o_Cnt2, bus.o_Cnt1}, 0);
      check("midrst_led", bus.o_LED, 0);
      check("midrst_tick", bus.o_Tick, 0);
      rst = 1'b0;
      cycles(GAP);
      check_status("post_reset");

`ifdef COUNTER_SEQ_DEBOUNCE_EN
      bus.i_Push[0] = 1'b0;
      cycles(3);
      bus.i_Push[0] = 1'b1;
      cycles(12);
      check("glitch_led", bus.o_LED, 0);
      bus.i_Push[0] = 1'b0;
      cycles(6);
      bus.i_Push[0] = 1'b1;
      check("db_before_run", bus.o_LED[0], 0);
      cycles(1);
      check("db_run", bus.o_LED[0], 1);
      cycles(GAP);
`endif

      cycles(20);
      check("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
